// File: rtl/phys_reg_free_list_pkg.sv
// Shared sizing, tag/pointer types and reset-image helper for the physical
// register free list.
package phys_reg_free_list_pkg;

  localparam int PHYS_REG_LENGTH  = 64;
  localparam int ARCH_REG_LENGTH  = 32;
  localparam int PHYS_REG_IDX_W   = $clog2(PHYS_REG_LENGTH);
  localparam int FREE_LIST_LENGTH = PHYS_REG_LENGTH - ARCH_REG_LENGTH;
  localparam int FL_DEPTH         = FREE_LIST_LENGTH;
  localparam int FL_PTR_W         = $clog2(FREE_LIST_LENGTH);

  typedef logic [PHYS_REG_IDX_W-1:0] phys_reg_idx_t;

  // Pointer carries one extra wrap bit so full and empty are distinguishable.
  typedef logic [FL_PTR_W:0] fl_ptr_t;

  // Tag held by free-list slot i out of reset: the registers above the
  // architectural set start out free.
  function automatic phys_reg_idx_t reset_tag(input int i);
    return phys_reg_idx_t'(ARCH_REG_LENGTH + i);
  endfunction

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags. Rename allocates at the
// speculative head, commit frees stale tags at the tail, and a committed
// head lets a flush restore every uncommitted allocation in one cycle.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc_req,
  output logic                      alloc_valid,
  output logic                      alloc_gnt,
  output logic [PHYS_REG_IDX_W-1:0] alloc_preg,
  input  logic                      rel_valid,
  input  logic [PHYS_REG_IDX_W-1:0] rel_preg,
  input  logic                      commit_alloc,
  input  logic                      flush,
  output logic [FL_PTR_W:0]         free_count,
  output logic                      err
);

  phys_reg_idx_t r_mem [FL_DEPTH];
  fl_ptr_t       r_head;
  fl_ptr_t       r_commit_head;
  fl_ptr_t       r_tail;
  logic          r_err;

  fl_ptr_t w_count;
  logic    w_empty;
  logic    w_full;
  logic    w_rel_ok;
  logic    w_rel_drop;
  logic    w_commit_ok;
  logic    w_commit_bad;
  fl_ptr_t w_commit_head_nxt;
  fl_ptr_t w_head_nxt;

  // Occupancy; wrap-bit arithmetic keeps 0..FL_DEPTH unambiguous.
  assign w_count = r_tail - r_head;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == fl_ptr_t'(FL_DEPTH));

  // Allocation side: tag is read straight from the head slot, no bypass
  // from a same-cycle release into an empty list.
  assign alloc_valid = ~w_empty;
  assign alloc_gnt   = alloc_req & ~w_empty & ~flush;
  assign alloc_preg  = r_mem[r_head[FL_PTR_W-1:0]];
  assign free_count  = w_count;
  assign err         = r_err;

  // A release into a full list would overwrite a free tag, so it is dropped.
  assign w_rel_ok   = rel_valid & ~w_full;
  assign w_rel_drop = rel_valid &  w_full;

  // Commit may only advance over allocations that actually happened.
  assign w_commit_ok  = commit_alloc & (r_commit_head != r_head);
  assign w_commit_bad = commit_alloc & (r_commit_head == r_head);

  assign w_commit_head_nxt = r_commit_head + fl_ptr_t'(w_commit_ok);

  // Flush rewinds the speculative head onto the (post-commit) committed head.
  assign w_head_nxt = flush ? w_commit_head_nxt : r_head + fl_ptr_t'(alloc_gnt);

  // Pointer and sticky-error state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head        <= '0;
      r_commit_head <= '0;
      r_tail        <= fl_ptr_t'(FL_DEPTH);
      r_err         <= 1'b0;
    end else begin
      r_head        <= w_head_nxt;
      r_commit_head <= w_commit_head_nxt;
      r_tail        <= r_tail + fl_ptr_t'(w_rel_ok);
      if (w_rel_drop || w_commit_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  // Tag storage; a release writes the stale tag at the tail slot.
  // NOTE: this array is reset on purpose, because out of reset it must already
  // hold the initial free tags; ordinary data memories would not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        r_mem[i] <= reset_tag(i);
      end
    end else if (w_rel_ok) begin
      r_mem[r_tail[FL_PTR_W-1:0]] <= rel_preg;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: a table of per-cycle vectors
// plus hand-written sequences, with expected outputs queued at drive time and
// compared at the following falling edge.
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  typedef struct {
    logic          gnt;
    phys_reg_idx_t preg;
    fl_ptr_t       cnt;
    logic          err;
  } exp_t;

  typedef struct {
    logic          req;
    logic          rel;
    phys_reg_idx_t rpreg;
    logic          cmt;
    logic          fl;
    exp_t          e;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          alloc_req;
  logic          alloc_valid;
  logic          alloc_gnt;
  phys_reg_idx_t alloc_preg;
  logic          rel_valid;
  phys_reg_idx_t rel_preg;
  logic          commit_alloc;
  logic          flush;
  fl_ptr_t       free_count;
  logic          err;

  int    n_checks;
  int    n_errors;
  exp_t  exp_q [$];
  string name_q[$];
  vec_t  tbl[12];

  phys_reg_free_list dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req    (alloc_req),
    .alloc_valid  (alloc_valid),
    .alloc_gnt    (alloc_gnt),
    .alloc_preg   (alloc_preg),
    .rel_valid    (rel_valid),
    .rel_preg     (rel_preg),
    .commit_alloc (commit_alloc),
    .flush        (flush),
    .free_count   (free_count),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input logic g, input int p, input int c, input logic e);
    exp_t x;
    x.gnt  = g;
    x.preg = phys_reg_idx_t'(p);
    x.cnt  = fl_ptr_t'(c);
    x.err  = e;
    return x;
  endfunction

  function automatic vec_t mk_vec(input logic rq, input logic rl, input int rp,
                                  input logic cm, input logic f, input exp_t e);
    vec_t v;
    v.req   = rq;
    v.rel   = rl;
    v.rpreg = phys_reg_idx_t'(rp);
    v.cmt   = cm;
    v.fl    = f;
    v.e     = e;
    return v;
  endfunction

  // Scoreboard monitor: compares the oldest queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check({n, ".gnt"},   int'(alloc_gnt),   int'(e.gnt));
      check({n, ".cnt"},   int'(free_count),  int'(e.cnt));
      check({n, ".valid"}, int'(alloc_valid), int'(e.cnt != '0));
      check({n, ".err"},   int'(err),         int'(e.err));
      if (e.cnt != '0) begin
        check({n, ".preg"}, int'(alloc_preg), int'(e.preg));
      end
    end
  end

  // Called at posedge+1: drive one cycle of inputs and queue its expectation.
  task automatic step(input string name, input vec_t v);
    alloc_req    = v.req;
    rel_valid    = v.rel;
    rel_preg     = v.rpreg;
    commit_alloc = v.cmt;
    flush        = v.fl;
    exp_q.push_back(v.e);
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req    = 1'b0;
    rel_valid    = 1'b0;
    rel_preg     = '0;
    commit_alloc = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    idle_inputs();

    // Allocate four, commit one, flush, then illegal commit and alloc+release.
    tbl[0]  = mk_vec(1, 0,  0, 0, 0, mk_exp(1, 32, 32, 0));
    tbl[1]  = mk_vec(1, 0,  0, 0, 0, mk_exp(1, 33, 31, 0));
    tbl[2]  = mk_vec(1, 0,  0, 0, 0, mk_exp(1, 34, 30, 0));
    tbl[3]  = mk_vec(1, 0,  0, 0, 0, mk_exp(1, 35, 29, 0));
    tbl[4]  = mk_vec(0, 0,  0, 1, 0, mk_exp(0, 36, 28, 0));
    tbl[5]  = mk_vec(0, 0,  0, 0, 1, mk_exp(0, 36, 28, 0));
    tbl[6]  = mk_vec(0, 0,  0, 0, 0, mk_exp(0, 33, 31, 0));
    tbl[7]  = mk_vec(1, 0,  0, 0, 1, mk_exp(0, 33, 31, 0));
    tbl[8]  = mk_vec(0, 0,  0, 1, 0, mk_exp(0, 33, 31, 0));
    tbl[9]  = mk_vec(0, 0,  0, 0, 0, mk_exp(0, 33, 31, 1));
    tbl[10] = mk_vec(1, 1, 36, 0, 0, mk_exp(1, 33, 31, 1));
    tbl[11] = mk_vec(0, 0,  0, 0, 0, mk_exp(0, 34, 31, 1));

    do_reset();
    check("rst.cnt",   int'(free_count),  32);
    check("rst.valid", int'(alloc_valid), 1);
    check("rst.preg",  int'(alloc_preg),  32);
    check("rst.gnt",   int'(alloc_gnt),   0);
    check("rst.err",   int'(err),         0);

    for (int i = 0; i < 12; i++) begin
      step($sformatf("tbl%0d", i), tbl[i]);
    end

    // Drain all 32 tags in order, then FIFO re-use of released tags.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step($sformatf("drain%0d", i), mk_vec(1, 0, 0, 0, 0, mk_exp(1, 32 + i, 32 - i, 0)));
    end
    step("empty_req", mk_vec(1, 0,  0, 0, 0, mk_exp(0, 0, 0, 0)));
    step("rel5",      mk_vec(0, 1,  5, 0, 0, mk_exp(0, 0, 0, 0)));
    step("rel40",     mk_vec(0, 1, 40, 0, 0, mk_exp(0, 5, 1, 0)));
    step("get5",      mk_vec(1, 0,  0, 0, 0, mk_exp(1, 5, 2, 0)));
    step("get40_rel9",mk_vec(1, 1,  9, 0, 0, mk_exp(1, 40, 1, 0)));
    step("hold9",     mk_vec(0, 0,  0, 0, 0, mk_exp(0, 9, 1, 0)));
    step("get9",      mk_vec(1, 0,  0, 0, 0, mk_exp(1, 9, 1, 0)));
    step("empty2",    mk_vec(0, 0,  0, 0, 0, mk_exp(0, 0, 0, 0)));
    step("nobypass",  mk_vec(1, 1,  7, 0, 0, mk_exp(0, 0, 0, 0)));
    step("after7",    mk_vec(0, 0,  0, 0, 0, mk_exp(0, 7, 1, 0)));

    // Commit and flush in the same cycle: flush target includes the commit.
    do_reset();
    step("cf_a0", mk_vec(1, 0, 0, 0, 0, mk_exp(1, 32, 32, 0)));
    step("cf_a1", mk_vec(1, 0, 0, 0, 0, mk_exp(1, 33, 31, 0)));
    step("cf_a2", mk_vec(1, 0, 0, 0, 0, mk_exp(1, 34, 30, 0)));
    step("cf_cf", mk_vec(1, 0, 0, 1, 1, mk_exp(0, 35, 29, 0)));
    step("cf_chk",mk_vec(0, 0, 0, 0, 0, mk_exp(0, 33, 31, 0)));

    // Release into a full list is dropped and flags a sticky error.
    do_reset();
    step("full_rel", mk_vec(0, 1, 3, 0, 0, mk_exp(0, 32, 32, 0)));
    step("full_err", mk_vec(0, 0, 0, 0, 0, mk_exp(0, 32, 32, 1)));
    step("full_sty", mk_vec(1, 0, 0, 0, 0, mk_exp(1, 32, 32, 1)));

    // Random traffic, then an asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 10; i++) begin
      alloc_req    = 1'($urandom_range(0, 1));
      rel_valid    = 1'($urandom_range(0, 1));
      rel_preg     = phys_reg_idx_t'($urandom_range(0, 63));
      commit_alloc = 1'($urandom_range(0, 1));
      flush        = 1'($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
    end
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    check("arst.cnt",   int'(free_count),  32);
    check("arst.preg",  int'(alloc_preg),  32);
    check("arst.err",   int'(err),         0);
    check("arst.valid", int'(alloc_valid), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    check("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Free list of physical register tags for the rename stage.
- Rename pops free tags (allocation end). ROB commit pushes back the stale tag of each retiring instruction (release end).
- Holds a speculative head and a committed head, so a pipeline flush returns every uncommitted allocation in one cycle.
- Sits between rename, the ROB commit logic and the flush controller.

Parameters:
- PHYS_REG_LENGTH, 64, number of physical registers (from general_defines).
- ARCH_REG_LENGTH, 32, number of architectural registers (from general_defines).
- FL_DEPTH, PHYS_REG_LENGTH-ARCH_REG_LENGTH (32), free-list capacity.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- alloc_req  in  1  rename requests one tag this cycle.
- alloc_valid  out  1  a free tag is available (count != 0).
- alloc_gnt  out  1  alloc_req & alloc_valid & ~flush; head advances on the next edge.
- alloc_preg  out  PHYS_REG_IDX_W  tag at the speculative head.
- rel_valid  in  1  commit releases one stale tag.
- rel_preg  in  PHYS_REG_IDX_W  tag being released.
- commit_alloc  in  1  a committed instruction's allocation becomes architectural.
- flush  in  1  squash all uncommitted allocations.
- free_count  out  FL_PTR_W+1  number of free tags.
- err  out  1  sticky protocol error.

Behaviour:
- Storage and pointers
  - Storage: FL_DEPTH x PHYS_REG_IDX_W register array.
  - Pointers head, commit_head and tail are each FL_PTR_W+1 bits. The MSB is a wrap bit; the low bits index the array.
  - count = tail - head, modulo 2^(FL_PTR_W+1).
- Reset (async, rst_n=0)
  - entry i = ARCH_REG_LENGTH+i, so tags 32..63.
  - head = commit_head = 0; tail = FL_DEPTH with wrap bit set.
  - Outputs: free_count=32, alloc_valid=1, alloc_preg=32, alloc_gnt=0, err=0.
  - Reset asserted mid-operation discards all state and returns to these values.
- Allocation
  - alloc_preg = array[head], with zero-cycle read latency.
  - On alloc_gnt, head increments at the edge.
  - When empty, alloc_gnt=0 and there is no bypass from the same-cycle release.
- Release
  - On rel_valid, write array[tail] = rel_preg and increment tail.
  - Release while count==FL_DEPTH is dropped and sets err.
- Commit
  - commit_alloc increments commit_head.
  - If commit_head==head (no outstanding allocation), the pulse is ignored and sets err.
- Flush
  - Next head = commit_head, including any same-cycle commit_alloc increment.
  - alloc_gnt is forced 0 during the flush cycle.
  - A same-cycle release still takes effect.
- Simultaneous alloc and release: both pointers advance and count is unchanged.
- Registered state vs combinational outputs:
  - free_count, alloc_valid and alloc_preg are derived from registered state.
  - alloc_gnt is combinational from inputs and state.
- err clears only on reset.
- Occupancy invariant: 0 <= count <= FL_DEPTH always holds.

Decomposition:
- Add to general_defines:
  - localparam FREE_LIST_LENGTH = PHYS_REG_LENGTH-ARCH_REG_LENGTH.
  - localparam FL_PTR_W = $clog2(FREE_LIST_LENGTH).
  - typedef logic [PHYS_REG_IDX_W-1:0] phys_reg_idx_t.
- No sub-module: array and pointer logic stay in one module.

Test Plan:
- Reset, then 32 consecutive alloc_req -> alloc_preg sequence 32,33,...,63; free_count reaches 0; alloc_valid=0 afterwards.
- Drain all 32 tags, release tags 5 then 40, then allocate twice -> grants return 5 then 40 (FIFO order); empty-cycle alloc_req gives no grant.
- Allocate 4 tags, commit_alloc once, flush -> next alloc_preg=33; free_count=31.
- Empty list; alloc_req and rel_valid (preg 7) in the same cycle -> no grant that cycle; next cycle alloc_valid=1 and alloc_preg=7.
- From reset, rel_valid with preg 3 -> release dropped, err=1, free_count stays 32.
- Assert rst_n=0 after 10 random operations -> free_count=32, alloc_preg=32, err=0 immediately (asynchronous).
